// File: rtl/brick_breaker_pkg.sv
// Shared constants, FSM state type and brick geometry helper
// for the Brick-Breaker game-state engine.
package brick_breaker_pkg;

    localparam int BALL_SIZE   = 20;
    localparam int PADDLE_W    = 74;
    localparam int PADDLE_Y    = 458;
    localparam int BRICK_W     = 57;
    localparam int BRICK_H     = 19;
    localparam int WALL_L      = 134;
    localparam int WALL_R      = 505;
    localparam int FLOOR_Y     = 479;
    localparam int BRICK_Y     = 40;
    localparam int BRICK_X0    = 144;
    localparam int BRICK_PITCH = 60;
    localparam int NUM_BRICKS  = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MOVE,
        S_CHK,
        S_COMMIT,
        S_LOST,
        S_WON
    } state_t;

    function automatic logic [9:0] brick_x(input logic [2:0] idx);
        return 10'(BRICK_X0 + BRICK_PITCH * int'(idx));
    endfunction

endpackage

// File: rtl/ball_physics_rect_overlap.sv
// Combinational overlap test of two axis-aligned boxes,
// each box covering the half-open ranges [x, x+w) and [y, y+h).
module rect_overlap (
    input  logic [9:0] ax_i,
    input  logic [9:0] ay_i,
    input  logic [9:0] aw_i,
    input  logic [9:0] ah_i,
    input  logic [9:0] bx_i,
    input  logic [9:0] by_i,
    input  logic [9:0] bw_i,
    input  logic [9:0] bh_i,
    output logic       hit_o
);

    assign hit_o = (ax_i < bx_i + bw_i) && (bx_i < ax_i + aw_i) &&
                   (ay_i < by_i + bh_i) && (by_i < ay_i + ah_i);

endmodule

// File: rtl/ball_physics.sv
// Per-frame Brick-Breaker engine: moves the ball, resolves walls,
// paddle and bricks over a fixed 8-cycle sequence after each tick.
module ball_physics
    import brick_breaker_pkg::*;
#(
    parameter int STEP    = 2,
    parameter int BALL_X0 = 300,
    parameter int BALL_Y0 = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [8:0] paddle_x,
    output logic [8:0] ball_x,
    output logic [8:0] ball_y,
    output logic [5:0] bricks_exist,
    output logic       lose,
    output logic       win
);

    localparam logic [9:0] STEP_W  = 10'(STEP);
    localparam logic [9:0] SZ      = 10'(BALL_SIZE);
    localparam logic [9:0] L_LIM   = 10'(WALL_L + STEP);
    localparam logic [9:0] L_POS   = 10'(WALL_L);
    localparam logic [9:0] R_POS   = 10'(WALL_R - BALL_SIZE);
    localparam logic [9:0] PAD_TOP = 10'(PADDLE_Y);
    localparam logic [9:0] PAD_RET = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0] FLOOR   = 10'(FLOOR_Y);
    localparam logic [2:0] LAST    = 3'(NUM_BRICKS - 1);

    state_t      state_q, state_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  nx_q, nx_d, ny_q, ny_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic        lp_q, lp_d, hit_q, hit_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  br_q, br_d, nbr_q, nbr_d;
    logic        lose_q, lose_d, win_q, win_d;

    logic [9:0]  xe, ye, wx, ny0, mv_ny;
    logic        wdx, mv_dy, mv_lose;
    logic        pad_hit, brk_hit;

    // dx=1 means moving right, dy=1 means moving down
    always_comb begin
        xe  = {1'b0, x_q};
        ye  = {1'b0, y_q};
        wx  = dx_q ? xe + STEP_W : xe - STEP_W;
        ny0 = dy_q ? ye + STEP_W : ye - STEP_W;
        wdx = dx_q;
        if (!dx_q && xe < L_LIM) begin
            wx  = L_POS;
            wdx = 1'b1;
        end
        if (dx_q && xe + STEP_W > R_POS) begin
            wx  = R_POS;
            wdx = 1'b0;
        end
    end

    rect_overlap u_pad (
        .ax_i (wx),
        .ay_i (ny0),
        .aw_i (SZ),
        .ah_i (SZ),
        .bx_i ({1'b0, paddle_x}),
        .by_i (PAD_TOP),
        .bw_i (10'(PADDLE_W)),
        .bh_i (SZ),
        .hit_o(pad_hit)
    );

    always_comb begin
        mv_ny = ny0;
        mv_dy = dy_q;
        if (!dy_q && ye < STEP_W) begin
            mv_ny = '0;
            mv_dy = 1'b1;
        end
        if (dy_q && pad_hit && ye + SZ <= PAD_TOP) begin
            mv_ny = PAD_RET;
            mv_dy = 1'b0;
        end
        mv_lose = (mv_ny + SZ > FLOOR);
    end

    rect_overlap u_brick (
        .ax_i (nx_q),
        .ay_i (ny_q),
        .aw_i (SZ),
        .ah_i (SZ),
        .bx_i (brick_x(idx_q)),
        .by_i (10'(BRICK_Y)),
        .bw_i (10'(BRICK_W)),
        .bh_i (10'(BRICK_H)),
        .hit_o(brk_hit)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        lp_d    = lp_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        br_d    = br_q;
        nbr_d   = nbr_q;
        lose_d  = lose_q;
        win_d   = win_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_WAIT;
            S_WAIT: if (frame_tick) state_d = S_MOVE;
            S_MOVE: begin
                nx_d    = wx;
                ny_d    = mv_ny;
                dx_d    = wdx;
                dy_d    = mv_dy;
                lp_d    = mv_lose;
                hit_d   = 1'b0;
                idx_d   = '0;
                nbr_d   = br_q;
                state_d = S_CHK;
            end
            S_CHK: begin
                // Index keeps stepping after a hit so latency is fixed
                if (!hit_q && nbr_q[idx_q] && brk_hit) begin
                    nbr_d[idx_q] = 1'b0;
                    dy_d         = ~dy_q;
                    hit_d        = 1'b1;
                end
                if (idx_q == LAST) state_d = S_COMMIT;
                else               idx_d   = idx_q + 3'd1;
            end
            S_COMMIT: begin
                x_d  = nx_q[8:0];
                y_d  = ny_q[8:0];
                br_d = nbr_q;
                if (lp_q) begin
                    lose_d  = 1'b1;
                    state_d = S_LOST;
                end else if (nbr_q == '0) begin
                    win_d   = 1'b1;
                    state_d = S_WON;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_LOST, S_WON: state_d = state_q;
            default: state_d = S_IDLE;
        endcase
        if (!start && state_q != S_LOST && state_q != S_WON) begin
            state_d = S_IDLE;
            x_d     = 9'(BALL_X0);
            y_d     = 9'(BALL_Y0);
            dx_d    = 1'b1;
            dy_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= 9'(BALL_X0);
            y_q    <= 9'(BALL_Y0);
            nx_q   <= '0;
            ny_q   <= '0;
            dx_q   <= 1'b1;
            dy_q   <= 1'b0;
            lp_q   <= 1'b0;
            hit_q  <= 1'b0;
            idx_q  <= '0;
            br_q   <= '1;
            nbr_q  <= '1;
            lose_q <= 1'b0;
            win_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            nx_q   <= nx_d;
            ny_q   <= ny_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            lp_q   <= lp_d;
            hit_q  <= hit_d;
            idx_q  <= idx_d;
            br_q   <= br_d;
            nbr_q  <= nbr_d;
            lose_q <= lose_d;
            win_q  <= win_d;
        end
    end

    assign ball_x       = x_q;
    assign ball_y       = y_q;
    assign bricks_exist = br_q;
    assign lose         = lose_q;
    assign win          = win_q;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: frame-count trajectory table
// plus hand sequences for latency, dropped ticks, start-low and win.
module tb_ball_physics;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       frame_tick;
    logic [8:0] paddle_x;
    logic [8:0] ball_x;
    logic [8:0] ball_y;
    logic [5:0] bricks_exist;
    logic       lose;
    logic       win;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ball_physics dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .frame_tick  (frame_tick),
        .paddle_x    (paddle_x),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .bricks_exist(bricks_exist),
        .lose        (lose),
        .win         (win)
    );

    typedef struct {
        bit         do_rst;
        int         frames;
        int         pad;
        int         ex;
        int         ey;
        logic [5:0] eb;
        bit         el;
        bit         ew;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int ey,
                           input logic [5:0] eb, input bit el, input bit ew);
        chk({tag, ".x"}, int'(ball_x), ex);
        chk({tag, ".y"}, int'(ball_y), ey);
        chk({tag, ".bricks"}, int'(bricks_exist), int'(eb));
        chk({tag, ".lose"}, int'(lose), int'(el));
        chk({tag, ".win"}, int'(win), int'(ew));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One tick pulse, then enough cycles for the 8-edge update
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{1, 1,   0,   302, 298, 6'b111111, 0, 0};
        vecs[1]  = '{0, 91,  0,   484, 116, 6'b111111, 0, 0};
        vecs[2]  = '{0, 1,   0,   485, 114, 6'b111111, 0, 0};
        vecs[3]  = '{0, 1,   0,   483, 112, 6'b111111, 0, 0};
        vecs[4]  = '{0, 26,  0,   431, 60,  6'b111111, 0, 0};
        vecs[5]  = '{0, 1,   0,   429, 58,  6'b101111, 0, 0};
        vecs[6]  = '{0, 1,   0,   427, 60,  6'b101111, 0, 0};
        vecs[7]  = '{0, 146, 0,   135, 352, 6'b101111, 0, 0};
        vecs[8]  = '{0, 1,   0,   134, 354, 6'b101111, 0, 0};
        vecs[9]  = '{0, 1,   0,   136, 356, 6'b101111, 0, 0};
        vecs[10] = '{0, 41,  200, 218, 438, 6'b101111, 0, 0};
        vecs[11] = '{0, 1,   200, 220, 438, 6'b101111, 0, 0};
        vecs[12] = '{0, 1,   200, 222, 436, 6'b101111, 0, 0};
        vecs[13] = '{1, 312, 0,   220, 440, 6'b101111, 0, 0};
        vecs[14] = '{0, 9,   0,   238, 458, 6'b101111, 0, 0};
        vecs[15] = '{0, 1,   0,   240, 460, 6'b101111, 1, 0};
        vecs[16] = '{0, 5,   0,   240, 460, 6'b101111, 1, 0};

        paddle_x = '0;
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].do_rst) begin
                do_reset();
                chk_all($sformatf("reset%0d", i), 300, 300, 6'b111111, 0, 0);
                go();
            end
            paddle_x = 9'(vecs[i].pad);
            frames(vecs[i].frames);
            chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                    vecs[i].eb, vecs[i].el, vecs[i].ew);
        end

        // Latency and a tick dropped while in CHK
        paddle_x = '0;
        do_reset();
        go();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("lat_hold.x", int'(ball_x), 300);
        chk("lat_hold.y", int'(ball_y), 300);
        @(negedge clk);
        chk("lat_upd.x", int'(ball_x), 302);
        chk("lat_upd.y", int'(ball_y), 298);
        repeat (20) @(negedge clk);
        chk_all("drop_tick", 302, 298, 6'b111111, 0, 0);

        // Start dropped mid-CHK parks the ball
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        chk_all("park", 300, 300, 6'b111111, 0, 0);
        repeat (20) @(negedge clk);
        chk_all("park_hold", 300, 300, 6'b111111, 0, 0);
        go();
        frames(1);
        chk_all("resume", 302, 298, 6'b111111, 0, 0);

        // Last brick hit wins; start low keeps brick state
        do_reset();
        @(negedge clk) force dut.br_q = 6'b100000;
        @(negedge clk) release dut.br_q;
        @(negedge clk);
        go();
        frames(1);
        chk_all("win_pre", 302, 298, 6'b100000, 0, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("keep_bricks", 300, 300, 6'b100000, 0, 0);
        go();
        frames(121);
        chk_all("win", 429, 58, 6'b000000, 0, 1);
        frames(3);
        chk_all("win_hold", 429, 58, 6'b000000, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
